alu_seq_32: RTL

ALU_SEQ_32 -- requirements
Module: alu_seq_32

---
 rtl/alu_seq_32.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_32.sv
// 32-bit AND/OR/ADD/SUB unit that streams its operands byte-serially through
// a single 8-bit ALU, least-significant byte first; 4-cycle fixed latency.

module eight_bit_ALU (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] sel,
    input  logic       carry_in,
    output logic [7:0] result_c,
    output logic       carry_out_c
);
    logic [8:0] sum_c;

    always_comb begin
        sum_c       = 9'(a) + 9'(b) + 9'(carry_in);
        result_c    = 8'h00;
        carry_out_c = 1'b0;
        case (sel)
            2'd0:    result_c = a & b;
            2'd1:    result_c = a | b;
            2'd2: begin
                result_c    = sum_c[7:0];
                carry_out_c = sum_c[8];
            end
            default: result_c = a ^ b;
        endcase
    end
endmodule

module alu_seq_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cout,
    output logic        zero
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [1:0]        idx;
    logic [DATA_W-1:0] a_q, b_q;
    logic [1:0]        op_q;
    logic              carry_q;

    logic [4:0]        sh_c;
    logic [7:0]        a_byte_c, b_byte_c, alu_res_c;
    logic [1:0]        alu_sel_c;
    logic              alu_co_c;
    logic [DATA_W-1:0] result_nxt_c;
    logic              arith_c;

    // Byte selection and result-byte merge for the current idx
    always_comb begin
        sh_c         = {idx, 3'b000};
        a_byte_c     = 8'(a_q >> sh_c);
        b_byte_c     = 8'(b_q >> sh_c);
        arith_c      = op_q[1];
        alu_sel_c    = arith_c ? 2'd2 : ((op_q == OP_OR) ? 2'd1 : 2'd0);
        result_nxt_c = (result & ~(32'h0000_00FF << sh_c)) | (32'(alu_res_c) << sh_c);
    end

    eight_bit_ALU u_alu (
        .a           (a_byte_c),
        .b           (b_byte_c),
        .sel         (alu_sel_c),
        .carry_in    (carry_q),
        .result_c    (alu_res_c),
        .carry_out_c (alu_co_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (idx == 2'd3) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, byte-serial datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            carry_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= (op == OP_SUB) ? ~b : b;
                        op_q    <= op;
                        carry_q <= (op == OP_ADD) ? cin : (op == OP_SUB);
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    result  <= result_nxt_c;
                    carry_q <= alu_co_c;
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        cout <= arith_c & alu_co_c;
                        zero <= (result_nxt_c == '0);
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end
endmodule
